// File: rtl/spec_pkg.sv
// spec_pkg
// Shared types and constants for the pipeline shadow scoreboards.
//   dii_id           : instruction sequence id at its default width
//   inflight_entry_t : one tracked instruction {seq, rd, rd_valid}
//   ERR_*            : bit positions inside the sticky error vector
//   next_seq         : modulo-increment helper for sequence ids
package spec_pkg;

  localparam int DII_W  = 23;
  localparam int DEF_RD_W = 5;

  typedef logic [DII_W-1:0] dii_id;

  typedef struct packed {
    dii_id               seq;
    logic [DEF_RD_W-1:0] rd;
    logic                rd_valid;
  } inflight_entry_t;

  localparam int ERR_OVF = 0;
  localparam int ERR_UNF = 1;
  localparam int ERR_ORD = 2;
  localparam int ERR_RD  = 3;
  localparam int ERR_GAP = 4;
  localparam int ERR_W   = 5;

  // Sequence ids wrap naturally at their own width.
  function automatic dii_id next_seq(input dii_id cur);
    return cur + dii_id'(1);
  endfunction

endpackage

// File: rtl/spec_circ_fifo.sv
// spec_circ_fifo
// In-order circular buffer with an arbitrary entry type, shared by the
// shadow trackers. Within one cycle, pop is applied first, then clear,
// then push, so a clear discards everything that was stored before the
// edge while still accepting a same-cycle push.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data at the tail (ignored if no room)
//   push_data   : entry to store
//   pop         : drop the head entry (ignored if empty)
//   clear       : discard all stored entries
//   head_data   : oldest stored entry (undefined when empty)
//   count       : registered occupancy
//   full, empty : registered occupancy flags
module spec_circ_fifo
  import spec_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  input  logic                   clear,
  output entry_t                 head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W-1:0] head_d, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop, do_push;
  logic [CNT_W-1:0] count_after_pop;

  // Work out which operations actually take effect this cycle and the
  // resulting pointers. Room for a push is judged after the pop/clear.
  always_comb begin
    do_pop          = pop && (count_q != '0);
    count_after_pop = count_q - CNT_W'(do_pop);
    do_push         = push && (clear || (count_after_pop != CNT_W'(DEPTH)));

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (clear) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(do_pop);
      count_d = count_after_pop;
    end

    if (do_push) begin
      tail_d  = tail_q + PTR_W'(1);
      count_d = count_d + CNT_W'(1);
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: a slot is only read after it was written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[tail_q] <= push_data;
    end
  end

  assign head_data = mem[head_q];
  assign count     = count_q;
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);

endmodule

// File: rtl/spec_inflight_tracker.sv
// spec_inflight_tracker
// Shadow scoreboard for the pipeline: every instruction leaving stage 1 is
// recorded in order, and every stage-3 retirement must match the oldest
// recorded instruction. Any violation sets a sticky error bit, and the
// sequence id involved in the first error is kept for debug.
// Ports:
//   CLK, RST_N          : clock, asynchronous active-low reset
//   iss_*               : instruction leaving stage 1 (seq, rd, rd_valid)
//   ret_*               : instruction retiring from stage 3
//   flush               : pipeline redirect, kills all in-flight entries
//   count, full, empty  : registered occupancy
//   err                 : sticky {gap, rd, order, underflow, overflow}
//   err_seq             : sequence id captured with the first error
module spec_inflight_tracker
  import spec_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SEQ_W = 23,
  parameter int RD_W  = 5
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   iss_valid,
  input  logic [SEQ_W-1:0]       iss_seq,
  input  logic [RD_W-1:0]        iss_rd,
  input  logic                   iss_rd_valid,
  input  logic                   ret_valid,
  input  logic [SEQ_W-1:0]       ret_seq,
  input  logic [RD_W-1:0]        ret_rd,
  input  logic                   ret_rd_valid,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic [ERR_W-1:0]       err,
  output logic [SEQ_W-1:0]       err_seq
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [RD_W-1:0]  rd;
    logic             rd_valid;
  } entry_t;

  entry_t           iss_entry;
  entry_t           head_entry;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             ret_pop;
  logic             iss_push;
  logic             full_after;
  logic [ERR_W-1:0] err_set;
  logic [SEQ_W-1:0] expect_seq;
  logic             have_last;
  logic [SEQ_W-1:0] last_seq;

  spec_circ_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (iss_push),
    .push_data (iss_entry),
    .pop       (ret_pop),
    .clear     (flush),
    .head_data (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Evaluate the cycle as retire, then flush, then issue. A retirement only
  // ever sees entries stored before this edge, so an instruction cannot
  // issue and retire in the same cycle. Mismatched retirements still pop so
  // that one bad retirement does not cascade into every later comparison.
  always_comb begin
    err_set    = '0;
    ret_pop    = 1'b0;
    iss_push   = 1'b0;
    full_after = 1'b0;
    expect_seq = last_seq + SEQ_W'(1);
    iss_entry  = '{seq: iss_seq, rd: iss_rd, rd_valid: iss_rd_valid};

    if (ret_valid) begin
      if (fifo_empty) begin
        err_set[ERR_UNF] = 1'b1;
      end else begin
        ret_pop = 1'b1;
        if (head_entry.seq != ret_seq) begin
          err_set[ERR_ORD] = 1'b1;
        end
        if ((head_entry.rd_valid != ret_rd_valid) ||
            (head_entry.rd_valid && ret_rd_valid && (head_entry.rd != ret_rd))) begin
          err_set[ERR_RD] = 1'b1;
        end
      end
    end

    full_after = !flush && ((fifo_count - CNT_W'(ret_pop)) == CNT_W'(DEPTH));

    if (iss_valid) begin
      if (full_after) begin
        err_set[ERR_OVF] = 1'b1;
      end else begin
        iss_push = 1'b1;
      end
      if (have_last && (iss_seq != expect_seq)) begin
        err_set[ERR_GAP] = 1'b1;
      end
    end
  end

  // Sticky errors and sequence continuity. The continuity history survives
  // a flush on purpose: a redirect must not be able to hide a skipped id.
  // err_seq prefers the retiring id because retire is evaluated first.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err       <= '0;
      err_seq   <= '0;
      have_last <= 1'b0;
      last_seq  <= '0;
    end else begin
      err <= err | err_set;
      if ((err == '0) && (err_set != '0)) begin
        if (err_set[ERR_UNF] || err_set[ERR_ORD] || err_set[ERR_RD]) begin
          err_seq <= ret_seq;
        end else begin
          err_seq <= iss_seq;
        end
      end
      if (iss_valid) begin
        last_seq  <= iss_seq;
        have_last <= 1'b1;
      end
    end
  end

  assign count = fifo_count;
  assign full  = fifo_full;
  assign empty = fifo_empty;

endmodule
